seq_shift_add_mul: RTL and testbench
====================================

// Module: seq_shift_add_mul
//
// PURPOSE
// - Parametrised sequential shift-add multiplier. Successor to the 2-bit combinational multiplier.
// - Multiplies two WIDTH-bit operands and produces a 2*WIDTH-bit product, one multiplier bit per clock.
// - Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake.
// - Sits between an operand producer and a result consumer in the arithmetic datapath.
//
// PARAMETERS
// - WIDTH  4  operand width in bits; legal range 2..32. Product width is 2*WIDTH.
//
// PORTS
// - clk        in   1        single clock, rising edge
// - rst_n      in   1        synchronous active-low reset
// - in_valid   in   1        operands a/b valid
// - in_ready   out  1        block can accept operands (high only in IDLE)
// - a          in   WIDTH    multiplicand
// - b          in   WIDTH    multiplier
// - out_valid  out  1        product valid (high only in DONE)
// - out_ready  in   1        consumer accepts product
// - product    out  2*WIDTH  a*b
// - busy       out  1        high in BUSY state
//
// BEHAVIOUR
// - Reset: rst_n is sampled low at a rising clk edge. Result: state=IDLE; in_ready=1; out_valid=0; busy=0; product=0.
//   All internal registers (accumulator, shifted multiplicand, multiplier shift register, bit counter) are cleared.
// - Reset has priority over every other event. Reset asserted in BUSY or DONE discards the operation; no out_valid follows.
// - FSM IDLE: in_ready=1.
//   - On an edge where in_valid=1, the block captures a and b, zero-extends a to 2*WIDTH bits, clears the accumulator, loads count=WIDTH and moves to BUSY.
//   - in_valid=0 keeps the FSM in IDLE. Operand values are ignored when they are not captured.
// - FSM BUSY: in_ready=0, busy=1. Inputs a, b and in_valid are ignored. Each edge does four things:
//   - if the multiplier LSB is 1, adds the shifted multiplicand to the accumulator;
//   - shifts the multiplicand left by 1;
//   - shifts the multiplier right by 1;
//   - decrements count.
//   - The edge on which count goes 1->0 writes the final sum to product and moves to DONE.
// - FSM DONE: out_valid=1; product is held stable.
//   - out_ready=1 at an edge moves to IDLE, with out_valid=0 and in_ready=1 after that edge.
//   - out_ready=0 holds the result indefinitely, with no change to product.
// - Latency: out_valid rises at the WIDTH-th edge after the accepting edge. Example: WIDTH=4 gives 4 cycles.
// - The minimum issue interval is WIDTH+2 cycles: accept, WIDTH BUSY edges, handshake edge. Operations never overlap.
// - The output handshake takes priority; no new operand is accepted in the same edge as out_ready.
// - in_valid may stay high through BUSY and DONE. The operand is captured only in IDLE.
// - Arithmetic: the sum is exact in 2*WIDTH bits with no overflow. The worst case is (2^W-1)^2 < 2^(2W).
// - After out_valid falls, product keeps its last value until the next completion or reset.
//
// CONFIGURATION
// - Macro SEQ_MUL_SIGNED_EN.
// - Undefined (default): unsigned operands and an unsigned product.
// - Defined: a, b and product are two's complement.
//   - On capture, the block stores |a|, |b| and sign = a[W-1] ^ b[W-1].
//   - On the final BUSY edge, product = sign ? -sum : sum, written in the same edge. Latency is unchanged.
//   - (-2^(W-1)) * (-2^(W-1)) = +2^(2W-2) must be exact. The magnitude of -2^(W-1) is taken in W+1 bits or treated as unsigned W bits.
//
// TESTING  (WIDTH=4 unless noted)
// - Reset: hold rst_n=0 for 2 edges, then release.
//   -> in_ready=1, out_valid=0, busy=0, product=0.
// - a=3, b=5, in_valid pulsed 1 cycle, out_ready=1.
//   -> out_valid high exactly 4 edges after accept, product=8'd15.
//   -> in_ready returns 1 one edge later.
// - Exhaustive sweep: all 256 a/b pairs, back-to-back, in_valid held high.
//   -> every product equals a*b; 15*15=8'd225; x*0=0.
//   -> in_ready is never high in BUSY or DONE.
// - Backpressure: 7*9 with out_ready=0 for 10 cycles.
//   -> out_valid stays 1 and product stays 8'd63 throughout; a/b changes are ignored.
//   -> out_ready=1 gives IDLE at the next edge.
// - Reset mid-op: start 15*15, drop rst_n at the second BUSY edge.
//   -> IDLE, product=0, no out_valid pulse.
//   -> the next op 2*3 gives 8'd6.
// - SEQ_MUL_SIGNED_EN defined:
//   -> -3*5 gives 8'hF1;
//   -> -8*-8 gives 8'h40;
//   -> -8*7 gives 8'hC8;
//   -> 7*7 gives 8'h31.
//   -> latency stays 4.

Source files
------------

// File: rtl/seq_shift_add_mul.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
// Operands arrive through a valid/ready handshake, and the product leaves through a second one.
//
// Ports:
//   clk, rst_n           clock (rising edge) and synchronous active-low reset
//   in_valid, in_ready   operand handshake (in_ready high only in IDLE)
//   a, b                 multiplicand and multiplier, WIDTH bits each
//   out_valid, out_ready product handshake (out_valid high only in DONE)
//   product              2*WIDTH-bit result, held until the next completion or reset
//   busy                 high while the shift-add loop is running
//
// Macro SEQ_MUL_SIGNED_EN: when defined, a, b and product are two's complement.
// The unsigned core then works on magnitudes and restores the sign on the last edge.
module seq_shift_add_mul #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    result;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             last;

`ifdef SEQ_MUL_SIGNED_EN
  logic sign;
  logic neg;

  // The magnitude of -2^(W-1) is 2^(W-1), which still fits in W unsigned bits.
  always_comb begin
    a_mag  = a[WIDTH-1] ? WIDTH'(-a) : a;
    b_mag  = b[WIDTH-1] ? WIDTH'(-b) : b;
    neg    = a[WIDTH-1] ^ b[WIDTH-1];
    result = sign ? PW'(-sum) : sum;
  end
`else
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    result = sum;
  end
`endif

  assign sum  = acc + (mplier[0] ? mcand : '0);
  assign last = (count == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      sign    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= '0;
            mcand  <= PW'(a_mag);
            mplier <= b_mag;
            count  <= CW'(WIDTH);
`ifdef SEQ_MUL_SIGNED_EN
            sign   <= neg;
`endif
          end
        end
        BUSY: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
          if (last) product <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Randomized and directed bench for seq_shift_add_mul.
// A scoreboard queue is filled by the driver and drained by a negedge monitor.
module tb_seq_shift_add_mul;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] product;
  logic          busy;

  seq_shift_add_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] p;
    int            c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  logic rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] model(logic [W-1:0] x, logic [W-1:0] y);
`ifdef SEQ_MUL_SIGNED_EN
    int sx;
    int sy;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    return PW'(sx * sy);
`else
    return PW'(int'(x) * int'(y));
`endif
  endfunction

  task automatic chk(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (in_ready && (busy || out_valid)) begin
        errors++;
        $display("FAIL ready_excl: in_ready=1 busy=%0b out_valid=%0b", busy, out_valid);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious: out_valid=1 with product %0h, expected none", product);
        end else begin
          if (!prev_valid) begin
            checks++;
            if (cyc - sb[0].c != W) begin
              errors++;
              $display("FAIL latency: got %0d expected %0d", cyc - sb[0].c, W);
            end
          end
          chk("product", product, sb[0].p);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
    prev_valid = out_valid;
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair and returns just after the accepting edge.
  task automatic issue(logic [W-1:0] x, logic [W-1:0] y, bit hold);
    int n;
    a = x;
    b = y;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 60) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b expected 1", in_ready);
    end else begin
      sb.push_back('{p: model(x, y), c: cyc + 1});
    end
    step();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  initial begin
    logic [PW-1:0] held;
    int n;

    step();
    step();
    chk("rst_in_ready", PW'(in_ready), PW'(1));
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    chk("rst_busy", PW'(busy), PW'(0));
    chk("rst_product", product, PW'(0));
    rst_n = 1'b1;

    issue(4'd3, 4'd5, 1'b0);
    drain();
    chk("idle_after_3x5", PW'(in_ready), PW'(1));
    chk("hold_after_3x5", product, model(4'd3, 4'd5));

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        issue(4'(i), 4'(j), 1'b1);
    in_valid = 1'b0;
    drain();

`ifdef SEQ_MUL_SIGNED_EN
    issue(4'hD, 4'd5, 1'b0);
    issue(4'h8, 4'h8, 1'b0);
    issue(4'h8, 4'd7, 1'b0);
    issue(4'd7, 4'd7, 1'b0);
    drain();
`endif

    out_ready = 1'b0;
    issue(4'd7, 4'd9, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("bp_valid", PW'(out_valid), PW'(1));
    held = product;
    for (int k = 0; k < 10; k++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    chk("bp_still_valid", PW'(out_valid), PW'(1));
    chk("bp_stable", product, held);
    out_ready = 1'b1;
    step();
    chk("bp_idle_ready", PW'(in_ready), PW'(1));
    chk("bp_idle_valid", PW'(out_valid), PW'(0));
    chk("bp_product_kept", product, model(4'd7, 4'd9));

    issue(4'd15, 4'd15, 1'b0);
    step();
    rst_n = 1'b0;
    void'(sb.pop_back());
    step();
    rst_n = 1'b1;
    chk("midrst_ready", PW'(in_ready), PW'(1));
    chk("midrst_product", product, PW'(0));
    for (int k = 0; k < 6; k++) step();
    chk("midrst_no_valid", PW'(out_valid), PW'(0));
    issue(4'd2, 4'd3, 1'b0);
    drain();

    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++)
      issue(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
